lb_tx: RTL and testbench

Transmit-side feeder for the 64-entry line buffer. Accepts 16-bit pixels from an upstream valid/ready stream and drives the buffer's write port (`wen`/`wdata`) under credit-based flow control, so the buffer can never be overrun. It mirrors buffer occupancy with a credit counter that is returned by the read side, and inserts a programmable bubble after each end-of-line. It sits directly upstream of the line buffer in the pixel pipeline.

---
 rtl/lb_pkg.sv | 7 +
 rtl/lb_tx_skid.sv | 42 ++++
 rtl/lb_tx.sv | 88 ++++++++
 tb/tb_lb_tx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// lb_pkg: shared widths, depth and transmit-side state encoding for the line buffer.
package lb_pkg;
  localparam int WORD_W   = 16;
  localparam int LB_DEPTH = 64;
  localparam int CRED_W   = 7;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_CR, GAP} lb_tx_state_t;
endpackage

// File: rtl/lb_tx_skid.sv
// lb_tx_skid: 2-entry valid/ready skid buffer with empty bypass; ready depends only on state.
module lb_tx_skid import lb_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [WORD_W-1:0] o_data,
  output logic              o_last,
  output logic              o_valid,
  input  logic              i_ready
);
  logic [1:0]        r_cnt;
  logic [WORD_W-1:0] r_d0, r_d1;
  logic              r_l0, r_l1;
  logic              w_in, w_out, w_store;
  logic [1:0]        w_idx;
  assign o_ready = rst_n & (r_cnt != 2'd2);
  assign o_valid = (r_cnt != 2'd0) | i_valid;
  assign o_data  = (r_cnt == 2'd0) ? i_data : r_d0;
  assign o_last  = (r_cnt == 2'd0) ? i_last : r_l0;
  assign w_in    = i_valid & o_ready;
  assign w_out   = o_valid & i_ready;
  // an empty buffer passes straight through when the consumer takes the word
  assign w_store = w_in & ~((r_cnt == 2'd0) & w_out);
  assign w_idx   = r_cnt - 2'(w_out);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_d0  <= '0;
      r_d1  <= '0;
      r_l0  <= 1'b0;
      r_l1  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 2'(w_in) - 2'(w_out);
      if (w_out && r_cnt == 2'd2) {r_d0, r_l0} <= {r_d1, r_l1};
      if (w_store && w_idx == 2'd0) {r_d0, r_l0} <= {i_data, i_last};
      if (w_store && w_idx == 2'd1) {r_d1, r_l1} <= {i_data, i_last};
    end
  end
endmodule

// File: rtl/lb_tx.sv
// lb_tx: credit-flow-controlled write feeder for the line buffer with end-of-line bubbles.
// Define LB_TX_SKID_EN to place a 2-entry skid buffer (registered in_ready) at the input.
module lb_tx import lb_pkg::*; #(
  parameter int DEPTH   = LB_DEPTH,
  parameter int EOL_GAP = 2,
  parameter int LCNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] wdata,
  output logic              wen,
  input  logic              rd_pop,
  output logic [CRED_W-1:0] credits,
  output logic [LCNT_W-1:0] line_cnt,
  output logic              err
);
  lb_tx_state_t      r_state, w_nxt, w_xfer_nxt;
  logic [3:0]        r_gap;
  logic [CRED_W-1:0] r_cred, w_cred_nxt;
  logic [WORD_W-1:0] r_wdata, w_d;
  logic [LCNT_W-1:0] r_lcnt;
  logic              r_wen, r_err, w_v, w_l, w_rdy, w_xfer, w_ovf;
  assign w_rdy = rst_n & (r_state == IDLE || r_state == SEND) & (r_cred != '0);
`ifdef LB_TX_SKID_EN
  lb_tx_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (in_data),
    .i_last  (in_last),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .o_data  (w_d),
    .o_last  (w_l),
    .o_valid (w_v),
    .i_ready (w_rdy)
  );
`else
  assign w_v      = in_valid;
  assign w_d      = in_data;
  assign w_l      = in_last;
  assign in_ready = w_rdy;
`endif
  assign w_xfer     = w_v & w_rdy;
  assign w_ovf      = rd_pop & ~w_xfer & (r_cred == CRED_W'(DEPTH));
  assign w_cred_nxt = w_ovf ? r_cred : r_cred - CRED_W'(w_xfer) + CRED_W'(rd_pop);
  always_comb begin
    w_xfer_nxt = (w_l && EOL_GAP > 0) ? GAP :
                 (r_cred == CRED_W'(1) && !rd_pop) ? WAIT_CR : SEND;
    w_nxt = r_state;
    case (r_state)
      IDLE, SEND: w_nxt = w_xfer ? w_xfer_nxt : IDLE;
      WAIT_CR:    w_nxt = rd_pop ? SEND : WAIT_CR;
      GAP:        w_nxt = (r_gap == 4'd0) ? IDLE : GAP;
      default:    w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap   <= '0;
      r_cred  <= CRED_W'(DEPTH);
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_lcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      // preloaded outside GAP so the bubble lasts exactly EOL_GAP cycles
      r_gap  <= (r_state != GAP) ? 4'(EOL_GAP - 1) : r_gap - 4'd1;
      r_cred <= w_cred_nxt;
      r_wen  <= w_xfer;
      if (w_xfer) r_wdata <= w_d;
      if (w_xfer && w_l) r_lcnt <= r_lcnt + 1'b1;
      if (w_ovf) r_err <= 1'b1;
    end
  end
  assign wdata    = r_wdata;
  assign wen      = r_wen;
  assign credits  = r_cred;
  assign line_cnt = r_lcnt;
  assign err      = r_err;
endmodule

// File: tb/tb_lb_tx.sv
// tb_lb_tx: table-driven and sequence checks of lb_tx with a write-data scoreboard.
module tb_lb_tx;
  import lb_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, rd_pop = 1'b0;
  logic        in_ready, wen, err;
  logic [15:0] wdata;
  logic [6:0]  credits;
  logic [9:0]  line_cnt;
  int          n_cmp = 0, n_bad = 0;
  logic [15:0] q[$];
  typedef struct {logic v; logic [15:0] d; logic l; logic p; logic rdy; logic [6:0] cred;} vec_t;
  vec_t tbl[11];
  logic r;

  lb_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .wdata    (wdata),
    .wen      (wen),
    .rd_pop   (rd_pop),
    .credits  (credits),
    .line_cnt (line_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [15:0] d, input logic l, input logic p, output logic rdy);
    logic xf;
    logic [15:0] e;
    in_valid = v; in_data = d; in_last = l; rd_pop = p;
    #1;
    rdy = in_ready;
    xf = v & rdy;
    if (xf) q.push_back(d);
    @(posedge clk); #1;
    chk("wen", {31'b0, wen}, {31'b0, xf});
    if (wen === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wdata: got 0x%0h expected no write", wdata);
      end else begin
        e = q.pop_front();
        chk("wdata", {16'b0, wdata}, {16'b0, e});
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; rd_pop = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_wen", {31'b0, wen}, 0);
    chk("rst_wdata", {16'b0, wdata}, 0);
    chk("rst_credits", {25'b0, credits}, 64);
    chk("rst_line_cnt", {22'b0, line_cnt}, 0);
    chk("rst_err", {31'b0, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 16'(i + 1), 1'b0, 1'b0, 1'b1, 7'(63 - i)};
    tbl[10] = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 7'd54};
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].p, r);
      chk($sformatf("tbl_rdy[%0d]", i), {31'b0, r}, {31'b0, tbl[i].rdy});
      chk($sformatf("tbl_credits[%0d]", i), {25'b0, credits}, {25'b0, tbl[i].cred});
    end

    do_reset();
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 16'(16'h100 + i), 1'b0, 1'b0, r);
      chk("fill_rdy", {31'b0, r}, 1);
      chk("fill_credits", {25'b0, credits}, 32'(63 - i));
    end
    cyc(1'b1, 16'h200, 1'b0, 1'b0, r);
    chk("empty_rdy", {31'b0, r}, 0);
    cyc(1'b1, 16'h200, 1'b0, 1'b1, r);
    chk("pop_rdy_same", {31'b0, r}, 0);
    chk("pop_credits", {25'b0, credits}, 1);
    cyc(1'b1, 16'h200, 1'b0, 1'b0, r);
    chk("pop_rdy_next", {31'b0, r}, 1);
    chk("w65_credits", {25'b0, credits}, 0);

    do_reset();
    for (int i = 0; i < 34; i++) cyc(1'b1, 16'(16'h300 + i), 1'b0, 1'b0, r);
    chk("c30", {25'b0, credits}, 30);
    cyc(1'b1, 16'h3FF, 1'b0, 1'b1, r);
    chk("xfer_pop_rdy", {31'b0, r}, 1);
    chk("xfer_pop_credits", {25'b0, credits}, 30);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, r);

    chk("line_cnt0", {22'b0, line_cnt}, 0);
    for (int k = 1; k <= 5; k++) cyc(1'b1, 16'(16'h400 + k), k == 5, 1'b0, r);
    chk("line_cnt1", {22'b0, line_cnt}, 1);
    cyc(1'b1, 16'h406, 1'b0, 1'b0, r);
    chk("gap_rdy1", {31'b0, r}, 0);
    cyc(1'b1, 16'h406, 1'b0, 1'b0, r);
    chk("gap_rdy2", {31'b0, r}, 0);
    cyc(1'b1, 16'h406, 1'b0, 1'b0, r);
    chk("gap_rdy3", {31'b0, r}, 1);
    chk("gap_credits", {25'b0, credits}, 24);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, r);

    do_reset();
    cyc(1'b0, 16'h0, 1'b0, 1'b1, r);
    chk("ovf_err", {31'b0, err}, 1);
    chk("ovf_credits", {25'b0, credits}, 64);
    cyc(1'b1, 16'h500, 1'b0, 1'b0, r);
    chk("ovf_err_hold", {31'b0, err}, 1);
    chk("ovf_credits63", {25'b0, credits}, 63);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, r);
    chk("ovf_err_hold2", {31'b0, err}, 1);
    do_reset();
    chk("err_cleared", {31'b0, err}, 0);

    for (int i = 0; i < 24; i++) cyc(1'b1, 16'(16'h600 + i), 1'b0, 1'b0, r);
    chk("c40", {25'b0, credits}, 40);
    in_valid = 1'b1; in_data = 16'hBEEF;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wen", {31'b0, wen}, 0);
    chk("arst_wdata", {16'b0, wdata}, 0);
    chk("arst_credits", {25'b0, credits}, 64);
    chk("arst_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    chk("arst_wen_edge", {31'b0, wen}, 0);
    @(negedge clk);
    q.delete();
    in_valid = 1'b0;
    rst_n = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0, r);
    chk("arst_rdy_after", {31'b0, r}, 1);
    chk("arst_credits_after", {25'b0, credits}, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
